// File: rtl/pricing_pkg.sv
// Shared constants and types for the path generator / pricing engine handshake.
package pricing_pkg;
  localparam int DATA_W         = 12;
  localparam int DAY_LEN        = 256;
  localparam int ADDR_W         = $clog2(DAY_LEN);
  localparam int DAY_NUM        = 64;
  localparam int PASSES_PER_DAY = 2;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_PASS1,
    RD_WAIT1,
    RD_PASS2,
    RD_WAIT2,
    RD_DONE
  } rd_state_t;
endpackage

// File: rtl/path_bank_ram.sv
// Two-bank sample store: one write port and one registered read port,
// both addressed by {bank, addr}.
module path_bank_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // Writer and reader always sit on different banks, so no read/write collision.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[{rd_bank, rd_addr}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/path_replay_buffer.sv
// Double-banked path store: captures one day per bank, streams it, replays it
// once on the first resend and releases the bank on the second.
module path_replay_buffer #(
  parameter int DATA_W  = pricing_pkg::DATA_W,
  parameter int DAY_LEN = pricing_pkg::DAY_LEN,
  parameter int ADDR_W  = pricing_pkg::ADDR_W,
  parameter int DAY_NUM = pricing_pkg::DAY_NUM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              resend,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              pass2,
  output logic [5:0]        day_idx,
  output logic              all_done
);
  import pricing_pkg::*;

  localparam int CW = (DAY_NUM > 2) ? $clog2(DAY_NUM) : 1;

  rd_state_t         state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CW-1:0]     banks_wr_q, banks_wr_d;
  logic              wr_stop_q, wr_stop_d;
  logic              wr_ready_q, wr_ready_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [5:0]        day_idx_q, day_idx_d;
  logic              all_done_q, all_done_d;
  logic              resend_q;
  logic              rd_valid_q, rd_valid_d;
  logic              pass2_q, pass2_d;
  logic              wr_fire, bank_done, issue, last_rd, release_bank;

  assign wr_fire   = wr_valid & wr_ready_q;
  assign bank_done = wr_fire & (wr_addr_q == ADDR_W'(DAY_LEN-1));
  assign issue     = (state_q == RD_PASS1) | (state_q == RD_PASS2);
  assign last_rd   = (rd_addr_q == ADDR_W'(DAY_LEN-1));

  always_comb begin
    wr_addr_d  = wr_addr_q;
    wr_bank_d  = wr_bank_q;
    banks_wr_d = banks_wr_q;
    wr_stop_d  = wr_stop_q;
    if (wr_fire) wr_addr_d = wr_addr_q + 1'b1;
    if (bank_done) begin
      wr_addr_d  = '0;
      wr_bank_d  = ~wr_bank_q;
      banks_wr_d = banks_wr_q + 1'b1;
      if (banks_wr_q == CW'(DAY_NUM-1)) wr_stop_d = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    rd_addr_d    = rd_addr_q;
    day_idx_d    = day_idx_q;
    all_done_d   = all_done_q;
    release_bank = 1'b0;
    case (state_q)
      RD_IDLE: if (full_q[rd_bank_q]) begin
        rd_addr_d = '0;
        state_d   = RD_PASS1;
      end
      RD_PASS1, RD_WAIT1: begin
        if (resend_q) begin
          rd_addr_d = '0;
          state_d   = RD_PASS2;
        end else if (state_q == RD_PASS1) begin
          if (last_rd) state_d = RD_WAIT1;
          else         rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      RD_PASS2, RD_WAIT2: begin
        if (resend_q) begin
          release_bank = 1'b1;
        end else if (state_q == RD_PASS2) begin
          if (last_rd) state_d = RD_WAIT2;
          else         rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      RD_DONE: state_d = RD_DONE;
      default: state_d = RD_IDLE;
    endcase
    // Releasing the last day ends the run; day_idx holds at its final value.
    if (release_bank) begin
      rd_bank_d = ~rd_bank_q;
      if (day_idx_q == 6'(DAY_NUM-1)) begin
        state_d    = RD_DONE;
        all_done_d = 1'b1;
      end else begin
        day_idx_d = day_idx_q + 6'd1;
        if (full_q[~rd_bank_q]) begin
          rd_addr_d = '0;
          state_d   = RD_PASS1;
        end else begin
          state_d = RD_IDLE;
        end
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (bank_done)    full_d[wr_bank_q] = 1'b1;
    if (release_bank) full_d[rd_bank_q] = 1'b0;
    wr_ready_d = ~full_d[wr_bank_d] & ~all_done_d & ~wr_stop_d;
    // A sample already issued when resend lands is read out but not presented.
    rd_valid_d = issue & ~resend_q;
    pass2_d    = issue & ~resend_q & (state_q == RD_PASS2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      banks_wr_q <= '0;
      wr_stop_q  <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      day_idx_q  <= '0;
      all_done_q <= 1'b0;
      resend_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      pass2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      banks_wr_q <= banks_wr_d;
      wr_stop_q  <= wr_stop_d;
      wr_ready_q <= wr_ready_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr_q  <= rd_addr_d;
      day_idx_q  <= day_idx_d;
      all_done_q <= all_done_d;
      resend_q   <= resend;
      rd_valid_q <= rd_valid_d;
      pass2_q    <= pass2_d;
    end
  end

  path_bank_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_fire),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_addr_q),
    .rd_data (rd_data)
  );

  assign wr_ready = wr_ready_q;
  assign rd_valid = rd_valid_q;
  assign pass2    = pass2_q;
  assign day_idx  = day_idx_q;
  assign all_done = all_done_q;
endmodule
